dcache_mem_assoc: RTL and testbench
===================================

# dcache_mem_assoc

Parametrised, set-associative successor to the direct-mapped data-cache array. It holds NUM_WAYS ways per set with true-LRU replacement and valid/dirty state per line. It tracks up to MAX_PENDING outstanding line misses by memory tag and installs returning fills into the victim way. A dirty victim produces a one-cycle write-back. It sits between dcache_controller and mem, under the same request/response conventions.

## Interface
- NUM_SETS, 16, sets (power of 2); IDX_W = $clog2(NUM_SETS)
- NUM_WAYS, 2, ways per set (power of 2, ≥2); AGE_W = $clog2(NUM_WAYS)
- TAG_WIDTH, 54, address tag bits
- BLOCK_WIDTH, 64, line data bits
- MEM_TAG_WIDTH, 4, memory transaction tag bits; value 0 means "none"
- MAX_PENDING, 4, outstanding-miss table entries

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low: all state clears immediately while reset==0
- index_in  input  IDX_W  set index of access
- tag_in  input  TAG_WIDTH  tag of access
- read_enable  input  1  read access this cycle
- write_enable  input  1  write access this cycle (never with read_enable)
- write_data_in  input  BLOCK_WIDTH  write-hit data
- mem_response  input  MEM_TAG_WIDTH  nonzero = memory accepted this cycle's miss under that tag
- mem_tag  input  MEM_TAG_WIDTH  nonzero = fill data for that tag on load_data_in
- load_data_in  input  BLOCK_WIDTH  fill data
- read_data_out  output  BLOCK_WIDTH  hit-way data, else 0
- data_is_valid  output  1  access hits
- data_is_dirty  output  1  hit line is dirty
- data_is_miss  output  1  new miss, allocatable; controller should issue to memory
- data_is_pending  output  1  line already outstanding; do not reissue
- set_busy  output  1  fill targets index_in this cycle; access not accepted, retry
- pending_full  output  1  all MAX_PENDING entries in use
- evict_valid  output  1  dirty victim written back this cycle
- evict_tag / evict_index  output  TAG_WIDTH / IDX_W  victim address
- store_data_out  output  BLOCK_WIDTH  victim data, else 0

## Operation
- Reset: every valid, dirty and pending entry is cleared. LRU age of way w is w, so way 0 is MRU. All outputs are 0.
- Access: the access is active when read_enable or write_enable is 1. hit = some way in set index_in is valid and has tag == tag_in. Lookups are combinational.
- Priority: set_busy, then hit (data_is_valid), then data_is_pending (a matching index+tag entry exists in the pending table), then a miss.
- data_is_miss = active & ~set_busy & ~hit & ~pending_match & ~pending_full. If pending_full is set, no miss is reported.
- Allocation: at the edge, when data_is_miss and mem_response≠0, store {mem_response, index_in, tag_in} in the lowest free entry. mem_response==0 means no allocation; the controller retries.
- Read hit: the hit way becomes MRU.
- Write hit: data is written, dirty is set, and the hit way becomes MRU.
- Write miss: nothing is written (no write-allocate in the array). The controller retries after the fill.
- LRU update: the touched way's age becomes 0. Ways whose age was below the touched way's old age increment.
- Fill: mem_tag≠0 and it matches a valid pending entry. Victim = lowest-numbered invalid way; if none, the way with age NUM_WAYS-1.
  - At the edge: install tag and data, valid=1, dirty=0, victim becomes MRU, and the entry is freed.
  - Same cycle, combinationally: set_busy if index_in equals the entry's index. If the victim is valid and dirty, evict_valid=1 and evict_tag/evict_index/store_data_out carry the victim.
- mem_tag matching no entry: ignored, no state change.
- Simultaneous fill and allocation: pending_full uses pre-edge state. A slot freed this edge is usable next cycle.
- A duplicate mem_response equal to an existing entry's tag is a protocol violation. The simulation assertion fires and the allocation is dropped.

## Timing
- All status/data outputs are combinational on inputs plus current state, in the same cycle.
- State updates on the rising edge.
- A filled line hits from the cycle after the fill edge.
- A write is visible to a read in the next cycle.
- Miss-to-fill latency is set by memory. There is no internal timeout.
- Asserting reset mid-operation drops all pending entries. Later fills for those tags are ignored.

## Test plan
- Reset, read idx2 tag1, mem_response=1 -> data_is_miss=1. Next cycle, same read with mem_response=0 -> data_is_pending=1, data_is_miss=0.
- Fill with mem_tag=1, load_data_in=0xffff -> set_busy=1 for idx2 that cycle. Next cycle, read idx2 tag1 -> data_is_valid=1, read_data_out=0xffff, data_is_dirty=0.
- Write idx2 tag1 with 0xcccc -> next read gives read_data_out=0xcccc, data_is_dirty=1.
- Fill idx2 tag5 (into way1), read tag5, then fill idx2 tag7 -> evict_valid=1, evict_tag=1, evict_index=2, store_data_out=0xcccc. Tag1 then misses; tags 5 and 7 hit.
- Allocate 4 misses (tags 1–4 on different sets), then a 5th miss -> pending_full=1, data_is_miss=0. Returning mem_tag=2 frees a slot; the 5th miss is allocatable next cycle.
- Pull reset low asynchronously between edges with 3 pending entries -> all outputs 0 at once. After release, mem_tag=1 fill is ignored and idx2 tag1 reports data_is_miss=1.

Source files
------------

// File: rtl/dcache_mem_assoc.sv
// rtl/dcache_mem_assoc.sv - set-associative data-cache array with LRU, dirty write-back and miss tracking
//
// Purpose:
//   Holds NUM_WAYS ways per set and replaces lines by true LRU. Each line
//   carries valid and dirty state. Up to MAX_PENDING outstanding line misses
//   are tracked by memory tag. A returning fill is installed into the victim
//   way, and a dirty victim is presented as a one-cycle write-back.
//
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   index_in        set index of the access
//   tag_in          tag of the access
//   read_enable     read access this cycle
//   write_enable    write access this cycle (never together with read_enable)
//   write_data_in   data written on a write hit
//   mem_response    nonzero = memory accepted this cycle's miss under that tag
//   mem_tag         nonzero = fill data for that tag is on load_data_in
//   load_data_in    fill data
//   read_data_out   hit-way data, else 0
//   data_is_valid   access hits
//   data_is_dirty   hit line is dirty
//   data_is_miss    new allocatable miss
//   data_is_pending line is already outstanding
//   set_busy        a fill targets index_in this cycle; retry the access
//   pending_full    every miss-table entry is in use
//   evict_valid     dirty victim written back this cycle
//   evict_tag       victim tag
//   evict_index     victim set index
//   store_data_out  victim data, else 0
module dcache_mem_assoc #(
   parameter int NUM_SETS      = 16,
   parameter int NUM_WAYS      = 2,
   parameter int TAG_WIDTH     = 54,
   parameter int BLOCK_WIDTH   = 64,
   parameter int MEM_TAG_WIDTH = 4,
   parameter int MAX_PENDING   = 4,
   localparam int IDX_W        = $clog2(NUM_SETS),
   localparam int AGE_W        = $clog2(NUM_WAYS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [IDX_W-1:0]         index_in,
   input  logic [TAG_WIDTH-1:0]     tag_in,
   input  logic                     read_enable,
   input  logic                     write_enable,
   input  logic [BLOCK_WIDTH-1:0]   write_data_in,
   input  logic [MEM_TAG_WIDTH-1:0] mem_response,
   input  logic [MEM_TAG_WIDTH-1:0] mem_tag,
   input  logic [BLOCK_WIDTH-1:0]   load_data_in,
   output logic [BLOCK_WIDTH-1:0]   read_data_out,
   output logic                     data_is_valid,
   output logic                     data_is_dirty,
   output logic                     data_is_miss,
   output logic                     data_is_pending,
   output logic                     set_busy,
   output logic                     pending_full,
   output logic                     evict_valid,
   output logic [TAG_WIDTH-1:0]     evict_tag,
   output logic [IDX_W-1:0]         evict_index,
   output logic [BLOCK_WIDTH-1:0]   store_data_out
);

   localparam int PEND_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;

   // line state
   logic [NUM_WAYS-1:0]    r_valid [NUM_SETS];
   logic [NUM_WAYS-1:0]    r_dirty [NUM_SETS];
   logic [AGE_W-1:0]       r_age   [NUM_SETS][NUM_WAYS];
   logic [TAG_WIDTH-1:0]   r_tag   [NUM_SETS][NUM_WAYS];
   logic [BLOCK_WIDTH-1:0] r_data  [NUM_SETS][NUM_WAYS];

   // outstanding-miss table
   logic [MAX_PENDING-1:0]   r_p_valid;
   logic [MEM_TAG_WIDTH-1:0] r_p_mtag [MAX_PENDING];
   logic [IDX_W-1:0]         r_p_idx  [MAX_PENDING];
   logic [TAG_WIDTH-1:0]     r_p_tag  [MAX_PENDING];

   logic               w_active;
   logic               w_hit;
   logic [AGE_W-1:0]   w_hit_way;
   logic               w_pmatch;
   logic               w_full;
   logic               w_free_found;
   logic [PEND_W-1:0]  w_free_slot;
   logic               w_dup;
   logic               w_fill;
   logic [PEND_W-1:0]  w_fill_slot;
   logic [IDX_W-1:0]   w_fill_idx;
   logic [TAG_WIDTH-1:0] w_fill_tag;
   logic               w_vic_found;
   logic [AGE_W-1:0]   w_vic_way;
   logic               w_busy;
   logic               w_acc_hit;
   logic               w_miss;
   logic               w_alloc_try;
   logic               w_alloc;
   logic               w_evict;

   assign w_active = read_enable | write_enable;
   assign w_full   = &r_p_valid;

   // hit lookup in the accessed set
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!w_hit && r_valid[index_in][w] && (r_tag[index_in][w] == tag_in)) begin
            w_hit     = 1'b1;
            w_hit_way = AGE_W'(w);
         end
      end
   end

   // miss-table searches: address match, lowest free slot, duplicate tag, fill slot
   always_comb begin
      w_pmatch     = 1'b0;
      w_free_found = 1'b0;
      w_free_slot  = '0;
      w_dup        = 1'b0;
      w_fill       = 1'b0;
      w_fill_slot  = '0;
      for (int p = 0; p < MAX_PENDING; p++) begin
         if (r_p_valid[p] && (r_p_idx[p] == index_in) && (r_p_tag[p] == tag_in))
            w_pmatch = 1'b1;
         if (!w_free_found && !r_p_valid[p]) begin
            w_free_found = 1'b1;
            w_free_slot  = PEND_W'(p);
         end
         if (r_p_valid[p] && (r_p_mtag[p] == mem_response))
            w_dup = 1'b1;
         if (!w_fill && (mem_tag != '0) && r_p_valid[p] && (r_p_mtag[p] == mem_tag)) begin
            w_fill      = 1'b1;
            w_fill_slot = PEND_W'(p);
         end
      end
   end

   assign w_fill_idx = r_p_idx[w_fill_slot];
   assign w_fill_tag = r_p_tag[w_fill_slot];

   // victim: lowest invalid way, otherwise the oldest way
   always_comb begin
      w_vic_found = 1'b0;
      w_vic_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!w_vic_found && !r_valid[w_fill_idx][w]) begin
            w_vic_found = 1'b1;
            w_vic_way   = AGE_W'(w);
         end
      end
      if (!w_vic_found) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            if (r_age[w_fill_idx][w] == AGE_W'(NUM_WAYS - 1))
               w_vic_way = AGE_W'(w);
         end
      end
   end

   assign w_busy      = w_fill && (w_fill_idx == index_in);
   assign w_acc_hit   = w_active && !w_busy && w_hit;
   assign w_miss      = w_active && !w_busy && !w_hit && !w_pmatch && !w_full;
   assign w_alloc_try = w_miss && (mem_response != '0);
   // a duplicate memory tag would make two entries answer one fill
   assign w_alloc     = w_alloc_try && !w_dup && w_free_found;
   assign w_evict     = w_fill && r_valid[w_fill_idx][w_vic_way] && r_dirty[w_fill_idx][w_vic_way];

   // outputs are forced low while reset is held so they clear asynchronously
   assign data_is_valid   = reset && w_acc_hit;
   assign data_is_dirty   = reset && w_acc_hit && r_dirty[index_in][w_hit_way];
   assign read_data_out   = data_is_valid ? r_data[index_in][w_hit_way] : '0;
   assign data_is_pending = reset && w_active && !w_busy && !w_hit && w_pmatch;
   assign data_is_miss    = reset && w_miss;
   assign set_busy        = reset && w_busy;
   assign pending_full    = reset && w_full;
   assign evict_valid     = reset && w_evict;
   assign evict_tag       = evict_valid ? r_tag[w_fill_idx][w_vic_way] : '0;
   assign evict_index     = evict_valid ? w_fill_idx : '0;
   assign store_data_out  = evict_valid ? r_data[w_fill_idx][w_vic_way] : '0;

   // control state: valid, dirty, LRU ages, miss-table occupancy.
   // set_busy guarantees a fill and an accepted hit never touch the same set.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_p_valid <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            r_valid[s] <= '0;
            r_dirty[s] <= '0;
            for (int w = 0; w < NUM_WAYS; w++)
               r_age[s][w] <= AGE_W'(w);
         end
      end else begin
         if (w_fill) begin
            r_valid[w_fill_idx][w_vic_way] <= 1'b1;
            r_dirty[w_fill_idx][w_vic_way] <= 1'b0;
            r_p_valid[w_fill_slot]         <= 1'b0;
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (AGE_W'(w) == w_vic_way)
                  r_age[w_fill_idx][w] <= '0;
               else if (r_age[w_fill_idx][w] < r_age[w_fill_idx][w_vic_way])
                  r_age[w_fill_idx][w] <= r_age[w_fill_idx][w] + 1'b1;
            end
         end
         if (w_acc_hit) begin
            if (write_enable)
               r_dirty[index_in][w_hit_way] <= 1'b1;
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (AGE_W'(w) == w_hit_way)
                  r_age[index_in][w] <= '0;
               else if (r_age[index_in][w] < r_age[index_in][w_hit_way])
                  r_age[index_in][w] <= r_age[index_in][w] + 1'b1;
            end
         end
         // the allocated slot is free pre-edge, so it never collides with the freed fill slot
         if (w_alloc)
            r_p_valid[w_free_slot] <= 1'b1;
      end
   end

   // payload storage; only meaningful where the matching valid bit is set
   always_ff @(posedge clock) begin
      if (reset) begin
         if (w_fill) begin
            r_tag[w_fill_idx][w_vic_way]  <= w_fill_tag;
            r_data[w_fill_idx][w_vic_way] <= load_data_in;
         end
         if (w_acc_hit && write_enable)
            r_data[index_in][w_hit_way] <= write_data_in;
         if (w_alloc) begin
            r_p_mtag[w_free_slot] <= mem_response;
            r_p_idx[w_free_slot]  <= index_in;
            r_p_tag[w_free_slot]  <= tag_in;
         end
      end
   end

   always @(posedge clock) begin
      if (reset)
         assert (!(w_alloc_try && w_dup));
   end

endmodule

// File: tb/tb_dcache_mem_assoc.sv
// tb/tb_dcache_mem_assoc.sv - directed self-checking bench for dcache_mem_assoc
module tb_dcache_mem_assoc;

   logic         clock;
   logic         reset;
   logic [3:0]   index_in;
   logic [53:0]  tag_in;
   logic         read_enable;
   logic         write_enable;
   logic [63:0]  write_data_in;
   logic [3:0]   mem_response;
   logic [3:0]   mem_tag;
   logic [63:0]  load_data_in;
   logic [63:0]  read_data_out;
   logic         data_is_valid;
   logic         data_is_dirty;
   logic         data_is_miss;
   logic         data_is_pending;
   logic         set_busy;
   logic         pending_full;
   logic         evict_valid;
   logic [53:0]  evict_tag;
   logic [3:0]   evict_index;
   logic [63:0]  store_data_out;

   int checks   = 0;
   int failures = 0;

   dcache_mem_assoc dut (
      .clock          (clock),
      .reset          (reset),
      .index_in       (index_in),
      .tag_in         (tag_in),
      .read_enable    (read_enable),
      .write_enable   (write_enable),
      .write_data_in  (write_data_in),
      .mem_response   (mem_response),
      .mem_tag        (mem_tag),
      .load_data_in   (load_data_in),
      .read_data_out  (read_data_out),
      .data_is_valid  (data_is_valid),
      .data_is_dirty  (data_is_dirty),
      .data_is_miss   (data_is_miss),
      .data_is_pending(data_is_pending),
      .set_busy       (set_busy),
      .pending_full   (pending_full),
      .evict_valid    (evict_valid),
      .evict_tag      (evict_tag),
      .evict_index    (evict_index),
      .store_data_out (store_data_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [3:0] idx,
                        input logic [53:0] tg, input logic [63:0] wd,
                        input logic [3:0] resp, input logic [3:0] mt, input logic [63:0] ld);
      read_enable   = rd;
      write_enable  = wr;
      index_in      = idx;
      tag_in        = tg;
      write_data_in = wd;
      mem_response  = resp;
      mem_tag       = mt;
      load_data_in  = ld;
   endtask

   task automatic nxt;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_valid", {63'd0, data_is_valid}, 64'd0);
      chk("rst_full",  {63'd0, pending_full}, 64'd0);
      chk("rst_evict", {63'd0, evict_valid}, 64'd0);
      chk("rst_rdata", read_data_out, 64'd0);
      nxt;
      nxt;
      reset = 1'b1;

      // first miss, then pending
      drive(1, 0, 2, 1, 0, 1, 0, 0); #4;
      chk("a_miss",    {63'd0, data_is_miss}, 64'd1);
      chk("a_pend0",   {63'd0, data_is_pending}, 64'd0);
      chk("a_valid0",  {63'd0, data_is_valid}, 64'd0);
      nxt;
      drive(1, 0, 2, 1, 0, 0, 0, 0); #4;
      chk("b_pend",    {63'd0, data_is_pending}, 64'd1);
      chk("b_miss0",   {63'd0, data_is_miss}, 64'd0);
      nxt;

      // fill tag1 into idx2
      drive(1, 0, 2, 1, 0, 0, 1, 64'hffff); #4;
      chk("c_busy",    {63'd0, set_busy}, 64'd1);
      chk("c_evict0",  {63'd0, evict_valid}, 64'd0);
      chk("c_valid0",  {63'd0, data_is_valid}, 64'd0);
      nxt;
      drive(1, 0, 2, 1, 0, 0, 0, 0); #4;
      chk("d_valid",   {63'd0, data_is_valid}, 64'd1);
      chk("d_rdata",   read_data_out, 64'hffff);
      chk("d_dirty0",  {63'd0, data_is_dirty}, 64'd0);
      nxt;

      // write hit then read back
      drive(0, 1, 2, 1, 64'hcccc, 0, 0, 0); #4;
      chk("e_whit",    {63'd0, data_is_valid}, 64'd1);
      nxt;
      drive(1, 0, 2, 1, 0, 0, 0, 0); #4;
      chk("f_rdata",   read_data_out, 64'hcccc);
      chk("f_dirty",   {63'd0, data_is_dirty}, 64'd1);
      nxt;

      // tag5 goes into the free way1
      drive(1, 0, 2, 5, 0, 2, 0, 0); #4;
      chk("g_miss5",   {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(0, 0, 0, 0, 0, 0, 2, 64'h5555); #4;
      chk("h_busy0",   {63'd0, set_busy}, 64'd0);
      chk("h_evict0",  {63'd0, evict_valid}, 64'd0);
      nxt;
      drive(1, 0, 2, 5, 0, 0, 0, 0); #4;
      chk("i_hit5",    {63'd0, data_is_valid}, 64'd1);
      chk("i_rdata5",  read_data_out, 64'h5555);
      nxt;

      // tag7 evicts the dirty LRU way0 (tag1)
      drive(1, 0, 2, 7, 0, 3, 0, 0); #4;
      chk("j_miss7",   {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(0, 0, 2, 0, 0, 0, 3, 64'h7777); #4;
      chk("k_evict",   {63'd0, evict_valid}, 64'd1);
      chk("k_etag",    {10'd0, evict_tag}, 64'd1);
      chk("k_eidx",    {60'd0, evict_index}, 64'd2);
      chk("k_sdata",   store_data_out, 64'hcccc);
      chk("k_busy",    {63'd0, set_busy}, 64'd1);
      nxt;
      drive(1, 0, 2, 1, 0, 0, 0, 0); #4;
      chk("l_miss1",   {63'd0, data_is_miss}, 64'd1);
      chk("l_valid1",  {63'd0, data_is_valid}, 64'd0);
      nxt;
      drive(1, 0, 2, 5, 0, 0, 0, 0); #4;
      chk("m_hit5",    {63'd0, data_is_valid}, 64'd1);
      nxt;
      drive(1, 0, 2, 7, 0, 0, 0, 0); #4;
      chk("n_hit7",    {63'd0, data_is_valid}, 64'd1);
      chk("n_rdata7",  read_data_out, 64'h7777);
      chk("n_dirty7",  {63'd0, data_is_dirty}, 64'd0);
      nxt;

      // fill the miss table
      drive(1, 0, 3, 1, 0, 1, 0, 0); #4;
      chk("p_miss1",   {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(1, 0, 4, 2, 0, 2, 0, 0); #4;
      chk("p_miss2",   {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(1, 0, 5, 3, 0, 3, 0, 0); #4;
      chk("p_miss3",   {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(1, 0, 6, 4, 0, 4, 0, 0); #4;
      chk("p_miss4",   {63'd0, data_is_miss}, 64'd1);
      chk("p_full0",   {63'd0, pending_full}, 64'd0);
      nxt;
      drive(1, 0, 7, 9, 0, 5, 0, 0); #4;
      chk("q_full",    {63'd0, pending_full}, 64'd1);
      chk("q_miss0",   {63'd0, data_is_miss}, 64'd0);
      nxt;
      drive(1, 0, 7, 9, 0, 5, 2, 64'h2222); #4;
      chk("r_full",    {63'd0, pending_full}, 64'd1);
      chk("r_miss0",   {63'd0, data_is_miss}, 64'd0);
      nxt;
      drive(1, 0, 7, 9, 0, 5, 0, 0); #4;
      chk("s_full0",   {63'd0, pending_full}, 64'd0);
      chk("s_miss",    {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(0, 0, 0, 0, 0, 0, 3, 64'h3333); #4;
      chk("t_full",    {63'd0, pending_full}, 64'd1);
      nxt;

      // three entries remain; reset between edges
      drive(1, 0, 4, 2, 0, 0, 0, 0); #2;
      chk("u_full0",   {63'd0, pending_full}, 64'd0);
      chk("u_hit2",    {63'd0, data_is_valid}, 64'd1);
      chk("u_rdata2",  read_data_out, 64'h2222);
      #1 reset = 1'b0;
      #1;
      chk("v_valid",   {63'd0, data_is_valid}, 64'd0);
      chk("v_rdata",   read_data_out, 64'd0);
      chk("v_miss",    {63'd0, data_is_miss}, 64'd0);
      #1 reset = 1'b1;
      drive(1, 0, 3, 1, 0, 0, 1, 64'h1111); #1;
      chk("w_busy0",   {63'd0, set_busy}, 64'd0);
      chk("w_pend0",   {63'd0, data_is_pending}, 64'd0);
      chk("w_miss",    {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(1, 0, 3, 1, 0, 0, 0, 0); #4;
      chk("x_valid0",  {63'd0, data_is_valid}, 64'd0);
      chk("x_miss",    {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(1, 0, 2, 1, 0, 0, 0, 0); #4;
      chk("y_miss",    {63'd0, data_is_miss}, 64'd1);
      nxt;
      drive(1, 0, 4, 2, 0, 0, 0, 0); #4;
      chk("z_miss",    {63'd0, data_is_miss}, 64'd1);
      chk("z_valid0",  {63'd0, data_is_valid}, 64'd0);
      nxt;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
